// File: rtl/backing_mem_tt.sv
// Backing store for the tiny cache: latency-modelled word array with a 1-entry posted write buffer.
// Define BMEM_INIT_PATTERN_EN to reset the array to the cache's default line pattern instead of zero.
module backing_mem_tt #(
    parameter int unsigned DATA_W  = 7,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_req_we,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    output logic              mem_rsp_valid,
    output logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              mem_busy
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StRdRsp, StWrAck} state_e;

    state_e            state;
    logic [3:0]        rd_cnt;
    logic [3:0]        dr_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [DATA_W-1:0] wbuf_data;
    logic              wbuf_valid;
    logic [DATA_W-1:0] mem [Depth];
    logic              req_fire;

`ifdef BMEM_INIT_PATTERN_EN
    // {a[1:0],a[3:2]} in the top nibble, zero below, inverted on odd addresses.
    function automatic logic [DATA_W-1:0] init_word(input int unsigned a);
        logic [3:0]        a4;
        logic [DATA_W+3:0] wide;
        a4   = 4'(a);
        wide = {a4[1:0], a4[3:2], {DATA_W{1'b0}}};
        return wide[DATA_W+3 -: DATA_W] ^ {DATA_W{a4[0]}};
    endfunction
`endif

    // A write must wait for the buffer to drain; reads never do.
    assign mem_req_ready = (state == StIdle) & ~rst & ~(mem_req_we & wbuf_valid);
    assign req_fire      = mem_req_valid & mem_req_ready;
    assign mem_busy      = (state != StIdle) | wbuf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            rd_cnt        <= '0;
            rd_addr       <= '0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_rdata <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_fire) begin
                        if (mem_req_we) begin
                            state         <= StWrAck;
                            mem_rsp_valid <= 1'b1;
                            mem_rsp_rdata <= mem_req_wdata;
                        end else begin
                            state   <= StRdWait;
                            rd_cnt  <= LatM1;
                            rd_addr <= mem_req_addr;
                        end
                    end
                end
                StRdWait: begin
                    if (rd_cnt == 4'd0) begin
                        state         <= StRdRsp;
                        mem_rsp_valid <= 1'b1;
                        // Buffered write is newer than the array word.
                        mem_rsp_rdata <= (wbuf_valid && (wbuf_addr == rd_addr)) ?
                                         wbuf_data : mem[rd_addr];
                    end else begin
                        rd_cnt <= rd_cnt - 4'd1;
                    end
                end
                StRdRsp, StWrAck: begin
                    state         <= StIdle;
                    mem_rsp_valid <= 1'b0;
                end
                default: begin
                    state         <= StIdle;
                    mem_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf_valid <= 1'b0;
            wbuf_addr  <= '0;
            wbuf_data  <= '0;
            dr_cnt     <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
`ifdef BMEM_INIT_PATTERN_EN
                mem[i] <= init_word(i);
`else
                mem[i] <= '0;
`endif
            end
        end else if (req_fire && mem_req_we) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= mem_req_addr;
            wbuf_data  <= mem_req_wdata;
            dr_cnt     <= LatM1;
        end else if (wbuf_valid) begin
            if (dr_cnt == 4'd0) begin
                mem[wbuf_addr] <= wbuf_data;
                wbuf_valid     <= 1'b0;
            end else begin
                dr_cnt <= dr_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_backing_mem_tt.sv
// Directed bench for backing_mem_tt: LATENCY=3 instance for most scenarios, LATENCY=1 for one.
module tb_backing_mem_tt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_valid = 1'b0, a_we = 1'b0;
    logic [3:0] a_addr = '0;
    logic [6:0] a_wdata = '0;
    logic       a_ready, a_rsp_valid, a_busy;
    logic [6:0] a_rdata;

    logic       b_valid = 1'b0, b_we = 1'b0;
    logic [3:0] b_addr = '0;
    logic [6:0] b_wdata = '0;
    logic       b_ready, b_rsp_valid, b_busy;
    logic [6:0] b_rdata;

    int checks = 0;
    int passed = 0;

`ifdef BMEM_INIT_PATTERN_EN
    localparam logic [6:0] Exp2 = 7'h40;
    localparam logic [6:0] Exp5 = 7'h57;
    localparam logic [6:0] Exp6 = 7'b1001000;
    localparam logic [6:0] ExpF = 7'h07;
`else
    localparam logic [6:0] Exp2 = 7'h00;
    localparam logic [6:0] Exp5 = 7'h00;
    localparam logic [6:0] Exp6 = 7'h00;
    localparam logic [6:0] ExpF = 7'h00;
`endif

    always #5 clk = ~clk;

    backing_mem_tt #(.DATA_W(7), .ADDR_W(4), .LATENCY(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_valid(a_valid),
        .mem_req_ready(a_ready),
        .mem_req_we   (a_we),
        .mem_req_addr (a_addr),
        .mem_req_wdata(a_wdata),
        .mem_rsp_valid(a_rsp_valid),
        .mem_rsp_rdata(a_rdata),
        .mem_busy     (a_busy)
    );

    backing_mem_tt #(.DATA_W(7), .ADDR_W(4), .LATENCY(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .mem_req_valid(b_valid),
        .mem_req_ready(b_ready),
        .mem_req_we   (b_we),
        .mem_req_addr (b_addr),
        .mem_req_wdata(b_wdata),
        .mem_rsp_valid(b_rsp_valid),
        .mem_rsp_rdata(b_rdata),
        .mem_busy     (b_busy)
    );

    // Present a request from a negedge; stalls = rising edges passed before acceptance, -1 on timeout.
    task automatic issue(input logic we, input logic [3:0] addr, input logic [6:0] data,
                         output int stalls);
        @(negedge clk);
        a_valid = 1'b1;
        a_we    = we;
        a_addr  = addr;
        a_wdata = data;
        stalls  = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (a_ready) begin
                @(posedge clk);
                #1;
                a_valid = 1'b0;
                return;
            end
            @(negedge clk);
            stalls++;
        end
        a_valid = 1'b0;
        stalls  = -1;
    endtask

    // Called just after the accepting edge; cyc = further rising edges until rsp_valid, -1 on timeout.
    task automatic wait_rsp(output int cyc);
        for (int i = 0; i < 20; i++) begin
            if (a_rsp_valid) begin
                cyc = i;
                return;
            end
            @(posedge clk);
            #1;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", a_ready);
        else passed++;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_rdata !== 7'h00 || a_busy !== 1'b0)
            $display("FAIL reset_outputs: got valid=%b rdata=%h busy=%b want 0 00 0",
                     a_rsp_valid, a_rdata, a_busy);
        else passed++;
        checks++;
        if (b_ready !== 1'b0 || b_rsp_valid !== 1'b0 || b_busy !== 1'b0)
            $display("FAIL reset_outputs_lat1: got ready=%b valid=%b busy=%b want 0 0 0",
                     b_ready, b_rsp_valid, b_busy);
        else passed++;
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic test_read_latency();
        int st, cyc;
        issue(1'b0, 4'h6, 7'h00, st);
        checks++;
        if (st !== 0) $display("FAIL rd6_stall: got %0d want 0", st);
        else passed++;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 3) $display("FAIL rd6_latency: got %0d want 3", cyc);
        else passed++;
        checks++;
        if (a_rdata !== Exp6) $display("FAIL rd6_data: got %h want %h", a_rdata, Exp6);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_rdata !== Exp6)
            $display("FAIL rd6_pulse_hold: got valid=%b rdata=%h want 0 %h",
                     a_rsp_valid, a_rdata, Exp6);
        else passed++;
    endtask

    task automatic test_write_forward();
        int st, cyc;
        issue(1'b1, 4'h2, 7'h55, st);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 0 || a_rdata !== 7'h55)
            $display("FAIL wr2_ack: got cyc=%0d rdata=%h want 0 55", cyc, a_rdata);
        else passed++;
        checks++;
        if (a_busy !== 1'b1) $display("FAIL wr2_busy: got %b want 1", a_busy);
        else passed++;
        issue(1'b0, 4'h2, 7'h00, st);
        checks++;
        if (st !== 1) $display("FAIL rd2_stall: got %0d want 1", st);
        else passed++;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 3 || a_rdata !== 7'h55)
            $display("FAIL rd2_data: got cyc=%0d rdata=%h want 3 55", cyc, a_rdata);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", a_busy);
        else passed++;
    endtask

    task automatic test_write_bubble();
        int st, cyc;
        issue(1'b1, 4'h1, 7'h11, st);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 0 || a_rdata !== 7'h11)
            $display("FAIL wr1_ack: got cyc=%0d rdata=%h want 0 11", cyc, a_rdata);
        else passed++;
        // Drain lands on the 3rd edge after accept; the 4th edge takes the next write.
        issue(1'b1, 4'h3, 7'h33, st);
        checks++;
        if (st !== 3) $display("FAIL wr3_bubble: got %0d stalls want 3", st);
        else passed++;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 0 || a_rdata !== 7'h33)
            $display("FAIL wr3_ack: got cyc=%0d rdata=%h want 0 33", cyc, a_rdata);
        else passed++;
        repeat (5) @(posedge clk);
        issue(1'b0, 4'h1, 7'h00, st);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 3 || a_rdata !== 7'h11)
            $display("FAIL rd1_array: got cyc=%0d rdata=%h want 3 11", cyc, a_rdata);
        else passed++;
        issue(1'b0, 4'h3, 7'h00, st);
        wait_rsp(cyc);
        checks++;
        if (a_rdata !== 7'h33) $display("FAIL rd3_array: got %h want 33", a_rdata);
        else passed++;
    endtask

    task automatic test_read_while_full();
        int st, cyc;
        issue(1'b1, 4'hA, 7'h3C, st);
        wait_rsp(cyc);
        issue(1'b0, 4'h5, 7'h00, st);
        checks++;
        if (st !== 1) $display("FAIL rd5_while_full_stall: got %0d want 1", st);
        else passed++;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 3 || a_rdata !== Exp5)
            $display("FAIL rd5_no_forward: got cyc=%0d rdata=%h want 3 %h", cyc, a_rdata, Exp5);
        else passed++;
        issue(1'b0, 4'hA, 7'h00, st);
        wait_rsp(cyc);
        checks++;
        if (a_rdata !== 7'h3C) $display("FAIL rdA_drained: got %h want 3c", a_rdata);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        int st, cyc;
        logic seen;
        issue(1'b1, 4'hF, 7'h2A, st);
        wait_rsp(cyc);
        issue(1'b0, 4'h6, 7'h00, st);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0 || a_rsp_valid !== 1'b0 || a_rdata !== 7'h00 || a_busy !== 1'b0)
            $display("FAIL midread_reset_outputs: got ready=%b valid=%b rdata=%h busy=%b want 0",
                     a_ready, a_rsp_valid, a_rdata, a_busy);
        else passed++;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen |= a_rsp_valid;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen |= a_rsp_valid;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL midread_no_rsp: got %b want 0", seen);
        else passed++;
        issue(1'b0, 4'h2, 7'h00, st);
        wait_rsp(cyc);
        checks++;
        if (cyc !== 3 || a_rdata !== Exp2)
            $display("FAIL rd2_restored: got cyc=%0d rdata=%h want 3 %h", cyc, a_rdata, Exp2);
        else passed++;
        issue(1'b0, 4'hF, 7'h00, st);
        wait_rsp(cyc);
        checks++;
        if (a_rdata !== ExpF) $display("FAIL rdF_restored: got %h want %h", a_rdata, ExpF);
        else passed++;
    endtask

    task automatic test_latency1();
        @(negedge clk);
        b_valid = 1'b1;
        b_we    = 1'b0;
        b_addr  = 4'hF;
        #1;
        checks++;
        if (b_ready !== 1'b1) $display("FAIL lat1_ready: got %b want 1", b_ready);
        else passed++;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        checks++;
        if (b_rsp_valid !== 1'b0) $display("FAIL lat1_early: got %b want 0", b_rsp_valid);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (b_rsp_valid !== 1'b1 || b_rdata !== ExpF)
            $display("FAIL lat1_rsp: got valid=%b rdata=%h want 1 %h", b_rsp_valid, b_rdata, ExpF);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (b_rsp_valid !== 1'b0 || b_busy !== 1'b0)
            $display("FAIL lat1_done: got valid=%b busy=%b want 0 0", b_rsp_valid, b_busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_forward();
        test_write_bubble();
        test_read_while_full();
        test_reset_mid_read();
        test_latency1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
